// File: rtl/fetch_if.sv
// Fetch-stage bus bundle.
//   Pipeline side : stall, redirect, target (in to fetch); npc, instr, hit (out of fetch)
//   Refill side   : mem_req, mem_addr (out of fetch); mem_rdata, mem_valid (in to fetch)
// master = fetch_unit view, slave = environment (hazard unit / branch unit / instruction memory).
interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] npc;
  logic [31:0] instr;
  logic        hit;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  modport master (
    input  stall, redirect, target, mem_rdata, mem_valid,
    output npc, instr, hit, mem_req, mem_addr
  );

  modport slave (
    output stall, redirect, target, mem_rdata, mem_valid,
    input  npc, instr, hit, mem_req, mem_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, direct-mapped I-cache (LINES x 4 words)
// with asynchronous lookup, and a 4-beat line refill over mem_req/mem_valid.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   bus.stall       hold PC
//   bus.redirect    load PC from bus.target (low 2 bits forced to 0)
//   bus.npc         PC + 4
//   bus.instr/hit   fetched word and its valid flag (instr = 0 when hit = 0)
//   bus.mem_req     refill burst in progress (registered)
//   bus.mem_addr    line-aligned refill address
//   bus.mem_rdata   refill beat data, qualified by bus.mem_valid
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned LINES    = 16
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic {
    LOOKUP,
    REFILL
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [31:0]        r_pc;
  logic [31:0]        r_data [LINES][4];
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [LINES-1:0]   r_valid;
  logic [31:0]        r_mem_addr;
  logic               r_mem_req;
  logic [1:0]         r_beat_cnt;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_off;
  logic [IDX_W-1:0]   w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic [31:0]        w_target;
  logic               w_lookup_hit;
  logic               w_miss;
  logic               w_beat;
  logic               w_last_beat;
  logic               w_hit;
  logic [31:0]        w_instr;

  assign w_idx      = r_pc[4 +: IDX_W];
  assign w_tag      = r_pc[31 -: TAG_W];
  assign w_off      = r_pc[3:2];
  assign w_fill_idx = r_mem_addr[4 +: IDX_W];
  assign w_fill_tag = r_mem_addr[31 -: TAG_W];
  assign w_target   = bus.target & ~32'd3;

  assign w_lookup_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  // A miss only starts a refill when the PC is actually going to be fetched.
  assign w_miss       = (r_state == LOOKUP) && !w_lookup_hit && !bus.redirect && !bus.stall;
  assign w_beat       = (r_state == REFILL) && bus.mem_valid;
  assign w_last_beat  = w_beat && (r_beat_cnt == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= LOOKUP;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOOKUP:  if (w_miss)      w_state_nxt = REFILL;
      REFILL:  if (w_last_beat) w_state_nxt = LOOKUP;
      default: w_state_nxt = LOOKUP;
    endcase
  end

  // Output logic
  always_comb begin
    w_hit   = 1'b0;
    w_instr = '0;
    if (r_state == LOOKUP && w_lookup_hit) begin
      w_hit   = 1'b1;
      w_instr = r_data[w_idx][w_off];
    end
  end

  assign bus.hit      = w_hit;
  assign bus.instr    = w_instr;
  assign bus.npc      = r_pc + 32'd4;
  assign bus.mem_req  = r_mem_req;
  assign bus.mem_addr = r_mem_addr;

  // Program counter
  always_ff @(posedge clk) begin
    if (rst)
      r_pc <= RESET_PC & ~32'd3;
    else if (bus.redirect)
      r_pc <= w_target;
    else if (!bus.stall && r_state == LOOKUP && w_lookup_hit)
      r_pc <= r_pc + 32'd4;
  end

  // Refill control and line valid bits. The refill address is latched so a
  // redirect during REFILL does not disturb the burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_beat_cnt <= '0;
    end else if (w_miss) begin
      r_mem_addr <= {r_pc[31:4], 4'b0000};
      r_beat_cnt <= '0;
      r_mem_req  <= 1'b1;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + 2'd1;
      if (r_beat_cnt == 2'd0)
        r_valid[w_fill_idx] <= 1'b0;
      if (w_last_beat) begin
        r_valid[w_fill_idx] <= 1'b1;
        r_mem_req           <= 1'b0;
      end
    end
  end

  // Cache data and tag storage (no reset; qualified by r_valid)
  always_ff @(posedge clk) begin
    if (!rst && w_beat) begin
      r_data[w_fill_idx][r_beat_cnt] <= bus.mem_rdata;
      if (r_beat_cnt == 2'd3)
        r_tag[w_fill_idx] <= w_fill_tag;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MiniCore pipeline: holds the program counter, looks it up in a small direct-mapped instruction cache, and presents the fetched word, PC+4 and a hit flag to the IF/ID pipeline register. On a miss it stops advancing the PC and refills one 4-word line from instruction memory over a req/valid burst. Branch redirects from downstream and stalls from the hazard unit steer the PC.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- LINES, 16, number of cache lines (power of 2, ≥2); 4 words per line fixed
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold PC (hazard unit); lookup outputs still driven
- redirect  in  1  branch/jump taken; load PC from target
- target  in  32  redirect PC (bits [1:0] ignored, treated as 00)
- npc  out  32  current PC + 4 (to IF/ID)
- instr  out  32  fetched instruction; 32'd0 when hit=0
- hit  out  1  instr valid this cycle
- mem_req  out  1  refill burst request (registered)
- mem_addr  out  32  line-aligned refill address, stable while mem_req=1
- mem_rdata  in  32  refill data beat
- mem_valid  in  1  mem_rdata valid this cycle; ignored when mem_req=0

## Operation
- Address split: pc[1:0] ignored; pc[3:2] word offset; pc[3+log2(LINES):4] index; remaining upper bits tag.
- Cache arrays: data[LINES][4], tag[LINES], valid[LINES]; read asynchronously from pc.
- States: LOOKUP, REFILL.
- LOOKUP: hit = valid[idx] && tag[idx]==pc tag; instr = hit ? data[idx][off] : 0; npc = pc+4 (mod 2^32, combinational in every state).
- PC update priority (each posedge): rst -> RESET_PC; else redirect -> target&~3; else stall -> hold; else state==LOOKUP && hit -> pc+4; else hold.
- Miss entry: in LOOKUP with hit=0, redirect=0, stall=0 -> latch fill address {pc tag, idx, 4'b0}, beat_cnt=0, mem_req<=1, go REFILL.
- REFILL: hit forced 0, instr=0. Each cycle mem_valid=1 writes mem_rdata to data[fill_idx][beat_cnt], beat_cnt++. On beat 3: tag[fill_idx]<=fill tag, valid[fill_idx]<=1, mem_req<=0, go LOOKUP. Line valid bit cleared on the first beat (eviction of old line).
- Redirect during REFILL: PC updates immediately; refill runs to completion using latched address; lookup of new PC begins on return to LOOKUP.
- Stall during REFILL: no effect on refill.
- Conflict: new line overwrites same index regardless of previous tag.

## Timing
- Reset values: pc=RESET_PC, state=LOOKUP, all valid=0, mem_req=0, mem_addr=0, beat_cnt=0; hence hit=0, instr=0, npc=RESET_PC+4 in first post-reset cycle.
- Hit: zero-latency; pc advances on the same edge IF/ID captures instr/npc.
- Miss detected cycle T -> mem_req=1 from T+1; with mem_valid high every cycle from T+1, beats at T+1..T+4, mem_req=0 and state=LOOKUP at T+5, hit=1 at T+5 for the missed PC. Memory wait cycles (mem_valid=0) extend REFILL 1:1.
- Reset mid-refill: abort; mem_req=0 next cycle; partially filled line stays invalid; late mem_valid ignored.
- Redirect and stall same cycle: redirect wins.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.

## Test plan
- Cold start, RESET_PC=0, memory returns word i = 32'h1000_0000+i with zero wait -> mem_req T+1..T+4, mem_addr=0, hit=1 at T+5 with instr=32'h1000_0000, npc=4; next 3 cycles hit, instr +1 each.
- Sequential run across line boundary at PC 0x0C->0x10 -> miss at 0x10, refill mem_addr=0x10, no PC advance until refill done.
- Redirect target=0x08 while line 0 valid -> next cycle pc=0x08, hit=1, instr=data word 2; redirect asserted with stall=1 still loads target.
- Redirect target=0x40 during refill of 0x10 -> burst completes at 0x10 (line valid), then miss on 0x40 with new mem_req.
- Stall held 3 cycles on hit -> pc, npc, instr constant; released -> pc+4.
- Reset after beat 2 of refill -> mem_req=0 next cycle, line invalid, re-lookup of RESET_PC misses; conflict test: LINES=16, fetch 0x000 then 0x100 -> second evicts first, refetch of 0x000 misses.
